pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side control for the program counter. Owns the 64-bit PC, issues instruction-memory requests over a req/ack handshake, and sequences stalls, taken-branch redirects and post-redirect flush bubbles. Sits between the hazard/branch-resolution logic and the instruction memory, and selects between the sequential (PC+4) and branch-target (base + offset<<1) next-PC sources.

## Interface
- RESET_PC, 40, PC value loaded on reset.
- FLUSH_CYCLES, 2, bubble cycles after a redirect; legal range 1..15.

- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous and active-high.
- stall  input  1  hazard unit request to hold fetch.
- branch_valid  input  1  branch resolved this cycle.
- branch_taken  input  1  qualifies branch_valid; 1 means redirect.
- branch_pc  input  64  PC of the resolving branch.
- branch_offset  input  64  sign-extended immediate from imm gen, unshifted.
- imem_ack  input  1  memory accepted and returned the current request.
- imem_req  output  1  fetch request, combinational from state (state==REQ).
- imem_addr  output  64  equals pc_out.
- pc_out  output  64  current PC register.
- fetch_valid  output  1  registered, 1-cycle pulse per completed fetch.
- fetch_pc  output  64  registered address of the completed fetch.
- flush  output  1  high during FLUSH state; kills younger pipeline stages.
- pc_sel  output  1  registered; 1 for the cycle after PC was loaded from a branch target, else 0.

## Operation
- States: IDLE, REQ, HOLD, FLUSH; 4-bit flush counter.
- Reset: pc=RESET_PC, state=IDLE, counter=0; imem_req=0, fetch_valid=0, fetch_pc=0, flush=0, pc_sel=0.
- Redirect = branch_valid & branch_taken; highest priority in every non-reset state. Target = branch_pc + (branch_offset << 1), mod 2^64. On redirect: pc=target, pc_sel=1 next cycle, state=FLUSH, counter=FLUSH_CYCLES-1, and any ack in the same cycle is discarded (no fetch_valid).
- branch_valid with branch_taken=0: no effect.
- IDLE: next state REQ if stall=0, else HOLD.
- REQ: imem_req=1, imem_addr=pc held stable until ack. On ack: fetch_valid=1 and fetch_pc=pc next cycle, pc=pc+4 (wraps mod 2^64). Next state REQ if stall=0, else HOLD. Without ack: stay REQ; stall is ignored while a request is outstanding.
- An ack that arrives while stall=1 is still delivered; downstream holds one skid entry.
- HOLD: imem_req=0, pc held. Go to REQ when stall=0.
- FLUSH: flush=1, imem_req=0. Counter decrements each cycle. At counter==0, next state is REQ if stall=0, else HOLD. A redirect during FLUSH reloads the target and restarts the counter.
- imem_req may drop without ack only on redirect or reset. The memory discards abandoned requests.

## Timing
- rst sampled at an edge forces the reset values after that edge, including mid-request and mid-flush.
- The first edge with rst=0 leaves IDLE. imem_req rises after the following edge: one cycle of IDLE.
- Back-to-back fetch with ack held high: one fetch per cycle, addresses +4 each cycle.
- Ack at edge N: fetch_valid high in cycle N+1 only.
- Redirect sampled at edge N: flush high for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES). imem_req with imem_addr=target follows from edge N+FLUSH_CYCLES if stall=0.
- Redirect, stall and ack in the same cycle resolve as redirect > ack > stall.

## Test plan
- Reset/sequential: rst high 2 cycles, then imem_ack tied 1 -> imem_addr 40, 44, 48, 52 on consecutive cycles; fetch_pc 40, 44, 48 each one cycle after its ack; all outputs 0/40 during reset.
- Wait states: ack delayed 3 cycles -> imem_req held, imem_addr stays 40, a single fetch_valid pulse, then addr 44.
- Taken branch: branch_pc=48, offset=8 -> pc_sel pulse, flush high exactly 2 cycles with imem_req=0, then imem_addr=64. A not-taken branch on the same cycle pattern causes no change.
- Stall: stall high 3 cycles starting in the ack cycle for addr 44 -> fetch_valid for 44 still pulses, imem_req low 3 cycles with pc=48, resume at 48. Stall plus redirect together -> redirect wins; after flush, enter HOLD if stall is still high.
- Arithmetic: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ack -> next addr 0. branch_pc=100, offset=-4 -> target 92. A redirect during FLUSH restarts the flush count.
- Reset mid-operation: rst asserted during FLUSH and during an un-acked REQ -> next cycle pc=40, state IDLE, flush=0, imem_req=0, no fetch_valid.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: owns the PC, issues imem requests, sequences stall/redirect/flush bubbles.
// Latency: imem_req one cycle after reset release; fetch_valid/fetch_pc one cycle after imem_ack; FLUSH_CYCLES bubbles per redirect.
// Backpressure: an outstanding request waits indefinitely for imem_ack; stall only gates the issue of the next request.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC     = 64'd40,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [63:0] branch_pc,
    input  logic [63:0] branch_offset,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [63:0] pc_out,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc,
    output logic        flush,
    output logic        pc_sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fetch_vld_d;
    logic [63:0] fetch_pc_d;
    logic        pc_sel_d;

    logic        redirect;
    logic [63:0] target;

    assign redirect = branch_valid & branch_taken;
    // Offset arrives unshifted from imm gen; halfword-scale it here, wrapping mod 2^64.
    assign target   = branch_pc + {branch_offset[62:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            cnt_q       <= 4'd0;
            fetch_valid <= 1'b0;
            fetch_pc    <= 64'd0;
            pc_sel      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            fetch_valid <= fetch_vld_d;
            fetch_pc    <= fetch_pc_d;
            pc_sel      <= pc_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fetch_vld_d = 1'b0;
        fetch_pc_d  = fetch_pc;
        pc_sel_d    = 1'b0;

        // Redirect beats ack beats stall; a same-cycle ack is dropped along with the old path.
        if (redirect) begin
            pc_d     = target;
            pc_sel_d = 1'b1;
            cnt_d    = FLUSH_INIT;
            state_d  = FLUSH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = stall ? HOLD : REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_vld_d = 1'b1;
                        fetch_pc_d  = pc_q;
                        pc_d        = pc_q + 64'd4;
                        state_d     = stall ? HOLD : REQ;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_d = REQ;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_d = stall ? HOLD : REQ;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign flush     = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed literal checks plus randomized traffic against a behavioural fetch model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, branch_valid, branch_taken, imem_ack;
    logic [63:0] branch_pc, branch_offset;

    logic        imem_req, fetch_valid, flush, pc_sel;
    logic [63:0] imem_addr, pc_out, fetch_pc;

    logic        w_req, w_fv, w_flush, w_sel;
    logic [63:0] w_addr, w_pc, w_fpc;

    pc_sequencer #(.RESET_PC(64'd40), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_valid(branch_valid), .branch_taken(branch_taken),
        .branch_pc(branch_pc), .branch_offset(branch_offset),
        .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc_out(pc_out), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .flush(flush), .pc_sel(pc_sel)
    );

    pc_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FLUSH_CYCLES(2)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_valid(branch_valid), .branch_taken(branch_taken),
        .branch_pc(branch_pc), .branch_offset(branch_offset),
        .imem_ack(imem_ack), .imem_req(w_req), .imem_addr(w_addr),
        .pc_out(w_pc), .fetch_valid(w_fv), .fetch_pc(w_fpc),
        .flush(w_flush), .pc_sel(w_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a request is either in flight, or we are waiting out bubbles, or waiting to issue.
    logic [63:0] m_pc, m_fpc;
    bit          m_fetching, m_fv, m_sel, m_valid;
    int          m_flush_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_valid      = 1'b1;
            m_pc         = 64'd40;
            m_fpc        = 64'd0;
            m_fv         = 1'b0;
            m_sel        = 1'b0;
            m_fetching   = 1'b0;
            m_flush_left = 0;
        end else if (m_valid) begin
            m_fv  = 1'b0;
            m_sel = 1'b0;
            if (branch_valid && branch_taken) begin
                m_pc         = branch_pc + branch_offset * 64'd2;
                m_sel        = 1'b1;
                m_fetching   = 1'b0;
                m_flush_left = 2;
            end else if (m_fetching) begin
                if (imem_ack) begin
                    m_fv       = 1'b1;
                    m_fpc      = m_pc;
                    m_pc       = m_pc + 64'd4;
                    m_fetching = !stall;
                end
            end else if (m_flush_left > 1) begin
                m_flush_left--;
            end else begin
                m_flush_left = 0;
                m_fetching   = !stall;
            end
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            chk("imem_req",    64'(imem_req),    64'(m_fetching));
            chk("imem_addr",   imem_addr,        m_pc);
            chk("pc_out",      pc_out,           m_pc);
            chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
            chk("fetch_pc",    fetch_pc,         m_fpc);
            chk("flush",       64'(flush),       64'(m_flush_left > 0));
            chk("pc_sel",      64'(pc_sel),      64'(m_sel));
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare();
    endtask

    task automatic drive(input bit r, input bit s, input bit bv, input bit bt, input bit a,
                         input logic [63:0] bp, input logic [63:0] bo);
        rst = r; stall = s; branch_valid = bv; branch_taken = bt; imem_ack = a;
        branch_pc = bp; branch_offset = bo;
    endtask

    initial begin
        logic [7:0] b;
        m_valid = 1'b0;
        m_pc = '0; m_fpc = '0; m_fv = 0; m_sel = 0; m_fetching = 0; m_flush_left = 0;
        drive(1, 0, 0, 0, 0, 64'd0, 64'd0);
        @(negedge clk);
        step();
        step();
        chk("rst_pc", pc_out, 64'd40);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_fv", 64'(fetch_valid), 64'd0);
        chk("rst_fpc", fetch_pc, 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_sel", 64'(pc_sel), 64'd0);
        chk("wrap_rst_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Sequential fetch with ack tied high
        drive(0, 0, 0, 0, 1, 64'd0, 64'd0);
        step();
        chk("seq_req", 64'(imem_req), 64'd1);
        chk("seq_addr40", imem_addr, 64'd40);
        chk("wrap_addr_pre", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("seq_addr44", imem_addr, 64'd44);
        chk("seq_fv", 64'(fetch_valid), 64'd1);
        chk("seq_fpc40", fetch_pc, 64'd40);
        chk("wrap_addr0", w_addr, 64'd0);
        step();
        chk("seq_addr48", imem_addr, 64'd48);
        chk("seq_fpc44", fetch_pc, 64'd44);
        step();
        chk("seq_addr52", imem_addr, 64'd52);
        chk("seq_fpc48", fetch_pc, 64'd48);

        // Wait states
        imem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", 64'(imem_req), 64'd1);
            chk("ws_addr", imem_addr, 64'd52);
            chk("ws_fv", 64'(fetch_valid), 64'd0);
        end
        imem_ack = 1;
        step();
        chk("ws_fv_pulse", 64'(fetch_valid), 64'd1);
        chk("ws_fpc", fetch_pc, 64'd52);
        chk("ws_addr56", imem_addr, 64'd56);
        imem_ack = 0;
        step();
        chk("ws_fv_end", 64'(fetch_valid), 64'd0);

        // Taken branch 48 + 8<<1 = 64
        drive(0, 0, 1, 1, 0, 64'd48, 64'd8);
        step();
        chk("br_sel", 64'(pc_sel), 64'd1);
        chk("br_flush1", 64'(flush), 64'd1);
        chk("br_req", 64'(imem_req), 64'd0);
        chk("br_target", imem_addr, 64'd64);
        drive(0, 0, 0, 0, 1, 64'd0, 64'd0);
        step();
        chk("br_flush2", 64'(flush), 64'd1);
        chk("br_sel_off", 64'(pc_sel), 64'd0);
        chk("br_fv_none", 64'(fetch_valid), 64'd0);
        step();
        chk("br_flush_end", 64'(flush), 64'd0);
        chk("br_req_resume", 64'(imem_req), 64'd1);
        chk("br_addr64", imem_addr, 64'd64);
        step();
        chk("br_fpc64", fetch_pc, 64'd64);
        drive(0, 0, 1, 0, 0, 64'd48, 64'd8);
        step();
        chk("nt_addr", imem_addr, 64'd68);
        chk("nt_flush", 64'(flush), 64'd0);
        chk("nt_sel", 64'(pc_sel), 64'd0);

        // Stall starting in the ack cycle
        drive(0, 1, 0, 0, 1, 64'd0, 64'd0);
        step();
        chk("st_fv", 64'(fetch_valid), 64'd1);
        chk("st_fpc", fetch_pc, 64'd68);
        chk("st_req0", 64'(imem_req), 64'd0);
        imem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("st_req_low", 64'(imem_req), 64'd0);
            chk("st_pc", pc_out, 64'd72);
        end
        stall = 0;
        step();
        chk("st_resume", 64'(imem_req), 64'd1);
        chk("st_addr72", imem_addr, 64'd72);

        // Stall + ack + redirect: 100 + (-4)<<1 = 92
        drive(0, 1, 1, 1, 1, 64'd100, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("sr_addr92", imem_addr, 64'd92);
        chk("sr_fv_drop", 64'(fetch_valid), 64'd0);
        chk("sr_flush", 64'(flush), 64'd1);
        drive(0, 1, 0, 0, 0, 64'd0, 64'd0);
        step();
        step();
        chk("sr_hold_flush", 64'(flush), 64'd0);
        chk("sr_hold_req", 64'(imem_req), 64'd0);
        stall = 0;
        step();
        chk("sr_req", 64'(imem_req), 64'd1);

        // Redirect during flush restarts the bubble count
        drive(0, 0, 1, 1, 0, 64'd0, 64'd16);
        step();
        chk("rf_addr32", imem_addr, 64'd32);
        drive(0, 0, 1, 1, 0, 64'd200, 64'd2);
        step();
        chk("rf_addr204", imem_addr, 64'd204);
        chk("rf_sel", 64'(pc_sel), 64'd1);
        drive(0, 0, 0, 0, 0, 64'd0, 64'd0);
        step();
        chk("rf_flush_still", 64'(flush), 64'd1);
        step();
        chk("rf_flush_done", 64'(flush), 64'd0);
        chk("rf_req", 64'(imem_req), 64'd1);

        // Reset mid-flush and mid-request
        drive(0, 0, 1, 1, 0, 64'd0, 64'd16);
        step();
        drive(1, 0, 0, 0, 0, 64'd0, 64'd0);
        step();
        chk("rmf_pc", pc_out, 64'd40);
        chk("rmf_flush", 64'(flush), 64'd0);
        chk("rmf_req", 64'(imem_req), 64'd0);
        drive(0, 0, 0, 0, 1, 64'd0, 64'd0);
        step();
        step();
        chk("rmr_addr44", imem_addr, 64'd44);
        imem_ack = 0;
        step();
        rst = 1;
        step();
        chk("rmr_pc", pc_out, 64'd40);
        chk("rmr_req", 64'(imem_req), 64'd0);
        chk("rmr_fv", 64'(fetch_valid), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(99) == 0);
            stall        = ($urandom_range(3) == 0);
            imem_ack     = ($urandom_range(1) == 1);
            branch_valid = ($urandom_range(7) == 0);
            branch_taken = ($urandom_range(1) == 1);
            branch_pc    = {$urandom(), $urandom()};
            if ($urandom_range(1) == 1) begin
                b             = 8'($urandom());
                branch_offset = {{56{b[7]}}, b};
            end else begin
                branch_offset = {$urandom(), $urandom()};
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
